// File: rtl/axi_wb_pkg.sv
// Shared definitions for the FIFO-to-AXI write burst engine (axi_wb).
// State encoding, fixed burst attributes and AXI response codes.
package axi_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW    = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_BWAIT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than a plain OKAY is reported as an error.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_wb.sv
// Pops N words from a FIFO and writes them as one AXI4 INCR burst.
// Define AXI_WB_BRESP_CHECK_EN to report non-OKAY write responses on err.
module axi_wb
    import axi_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          arg_1_rdata,
    input  logic [ADDR_W-1:0]   arg_2_rdata,
    input  logic [DATA_W-1:0]   arg_0_out_data,
    input  logic                arg_0_read_ready,
    output logic                arg_0_read_valid,
    output logic [ADDR_W-1:0]   arg_3_s_axi_awaddr,
    output logic [7:0]          arg_3_s_axi_awlen,
    output logic [2:0]          arg_3_s_axi_awsize,
    output logic [1:0]          arg_3_s_axi_awburst,
    output logic                arg_3_s_axi_awvalid,
    input  logic                arg_3_s_axi_awready,
    output logic [DATA_W-1:0]   arg_3_s_axi_wdata,
    output logic [DATA_W/8-1:0] arg_3_s_axi_wstrb,
    output logic                arg_3_s_axi_wlast,
    output logic                arg_3_s_axi_wvalid,
    input  logic                arg_3_s_axi_wready,
    input  logic [1:0]          arg_3_s_axi_bresp,
    input  logic                arg_3_s_axi_bvalid,
    output logic                arg_3_s_axi_bready,
    output logic                valid,
    output logic                err
);

    state_t              state_q, state_d;
    logic [7:0]          awlen_q, awlen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          beat_q, beat_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                last_beat;

    // awlen holds N-1, so the final beat is the one whose index equals awlen.
    assign last_beat = (beat_q == awlen_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            awlen_q <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            awlen_q <= awlen_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        awlen_d = awlen_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d  = 1'b0;
                    beat_d = '0;
                    if (arg_1_rdata != 8'd0) begin
                        awlen_d = arg_1_rdata - 8'd1;
                        addr_d  = arg_2_rdata;
                        state_d = ST_AW;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_AW: begin
                if (arg_3_s_axi_awready) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (arg_0_read_ready) begin
                    wdata_d = arg_0_out_data;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (arg_3_s_axi_wready) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = last_beat ? ST_BWAIT : ST_FETCH;
                end
            end
            ST_BWAIT: begin
                if (arg_3_s_axi_bvalid) begin
                    state_d = ST_DONE;
`ifdef AXI_WB_BRESP_CHECK_EN
                    err_d = resp_is_error(arg_3_s_axi_bresp);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifndef AXI_WB_BRESP_CHECK_EN
    logic unused_bresp;
    assign unused_bresp = ^arg_3_s_axi_bresp;
`endif

    // Handshake outputs decode straight from state so reset clears them at once.
    assign arg_0_read_valid    = (state_q == ST_FETCH);
    assign arg_3_s_axi_awvalid = (state_q == ST_AW);
    assign arg_3_s_axi_wvalid  = (state_q == ST_SEND);
    assign arg_3_s_axi_wlast   = (state_q == ST_SEND) && last_beat;
    assign arg_3_s_axi_bready  = (state_q == ST_BWAIT);
    assign valid               = (state_q == ST_DONE);

    assign arg_3_s_axi_awaddr  = addr_q;
    assign arg_3_s_axi_awlen   = awlen_q;
    assign arg_3_s_axi_awsize  = AXI_SIZE_4B;
    assign arg_3_s_axi_awburst = AXI_BURST_INCR;
    assign arg_3_s_axi_wdata   = wdata_q;
    assign arg_3_s_axi_wstrb   = '1;
    assign err                 = err_q;

endmodule

// File: tb/tb_axi_wb.sv
// Directed self-checking bench for axi_wb: bursts, stalls, reset abort, bresp.
module tb_axi_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  arg_1_rdata = '0;
    logic [15:0] arg_2_rdata = '0;
    logic [31:0] arg_0_out_data;
    logic        fifo_rdy = 1'b1;
    logic        arg_0_read_valid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b1;
    logic        bready;
    logic        valid;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: word k of the stream is A5A5_0000 + k.
    int fifo_idx = 0;
    assign arg_0_out_data = 32'hA5A5_0000 + 32'(fifo_idx);

    int          pop_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int          awv_cyc = 0, wv_cyc = 0, rv_cyc = 0;
    logic [31:0] w_data_log [16];
    logic        w_last_log [16];
    logic [15:0] aw_addr_log;
    logic [7:0]  aw_len_log;

    always #5 clk = ~clk;

    axi_wb #(.DATA_W(32), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .arg_1_rdata(arg_1_rdata), .arg_2_rdata(arg_2_rdata),
        .arg_0_out_data(arg_0_out_data), .arg_0_read_ready(fifo_rdy),
        .arg_0_read_valid(arg_0_read_valid),
        .arg_3_s_axi_awaddr(awaddr), .arg_3_s_axi_awlen(awlen),
        .arg_3_s_axi_awsize(awsize), .arg_3_s_axi_awburst(awburst),
        .arg_3_s_axi_awvalid(awvalid), .arg_3_s_axi_awready(awready),
        .arg_3_s_axi_wdata(wdata), .arg_3_s_axi_wstrb(wstrb),
        .arg_3_s_axi_wlast(wlast), .arg_3_s_axi_wvalid(wvalid),
        .arg_3_s_axi_wready(wready), .arg_3_s_axi_bresp(bresp),
        .arg_3_s_axi_bvalid(bvalid), .arg_3_s_axi_bready(bready),
        .valid(valid), .err(err)
    );

    // Handshake monitor: logs every transfer seen at the active edge.
    always @(posedge clk) begin
        if (awvalid) awv_cyc++;
        if (wvalid) wv_cyc++;
        if (arg_0_read_valid) rv_cyc++;
        if (arg_0_read_valid && fifo_rdy) begin
            pop_cnt++;
            fifo_idx++;
        end
        if (awvalid && awready) begin
            aw_cnt++;
            aw_addr_log = awaddr;
            aw_len_log  = awlen;
        end
        if (wvalid && wready) begin
            if (w_cnt < 16) begin
                w_data_log[w_cnt] = wdata;
                w_last_log[w_cnt] = wlast;
            end
            w_cnt++;
            $display("[TB] beat %0d data=%h last=%b", w_cnt, wdata, wlast);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        pop_cnt = 0; aw_cnt = 0; w_cnt = 0;
        awv_cyc = 0; wv_cyc = 0; rv_cyc = 0;
    endtask

    task automatic start_burst(input logic [7:0] n, input logic [15:0] addr);
        arg_1_rdata = n;
        arg_2_rdata = addr;
        start = 1'b1;
        step();
        start = 1'b0;
        $display("[TB] start N=%0d addr=%h", n, addr);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({awvalid, wvalid, arg_0_read_valid, bready, wlast, valid, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {awvalid, wvalid, arg_0_read_valid, bready, wlast, valid, err});
        end
        n_tests++;
        if ({awaddr, awlen, wdata} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {awaddr, awlen, wdata});
        end
        step(); step();
        rst = 1'b0;
        step();
        n_tests++;
        if (valid !== 1'b0 || awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b awvalid=%b want 0 0", valid, awvalid);
        end
        n_tests++;
        if ({awsize, awburst, wstrb} !== {3'b010, 2'b01, 4'hF}) begin
            n_fail++;
            $display("FAIL consts: got %b want 010_01_1111", {awsize, awburst, wstrb});
        end
    endtask

    task automatic test_burst4();
        bit ok;
        int base;
        clear_logs();
        base = fifo_idx;
        start_burst(8'd4, 16'h0100);
        n_tests++;
        if (awvalid !== 1'b1 || awaddr !== 16'h0100 || awlen !== 8'd3) begin
            n_fail++;
            $display("FAIL b4_aw: awvalid=%b addr=%h len=%0d want 1 0100 3", awvalid, awaddr, awlen);
        end
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b4_timeout: valid never rose");
        end
        n_tests++;
        if (aw_cnt !== 1 || w_cnt !== 4 || pop_cnt !== 4) begin
            n_fail++;
            $display("FAIL b4_counts: aw=%0d w=%0d pop=%0d want 1 4 4", aw_cnt, w_cnt, pop_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (w_data_log[k] !== 32'hA5A5_0000 + 32'(base + k) || w_last_log[k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL b4_beat%0d: data=%h last=%b want %h %b", k, w_data_log[k],
                         w_last_log[k], 32'hA5A5_0000 + 32'(base + k), (k == 3));
            end
        end
        n_tests++;
        if (aw_addr_log !== 16'h0100 || aw_len_log !== 8'd3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b4_awlog: addr=%h len=%0d err=%b want 0100 3 0", aw_addr_log, aw_len_log, err);
        end
    endtask

    task automatic test_single();
        bit ok;
        int base;
        clear_logs();
        base = fifo_idx;
        start_burst(8'd1, 16'h0200);
        n_tests++;
        if (awlen !== 8'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL n1_aw: awlen=%0d valid=%b want 0 0", awlen, valid);
        end
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1 || w_cnt !== 1 || pop_cnt !== 1 || w_last_log[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL n1_burst: done=%b w=%0d pop=%0d last=%b want 1 1 1 1",
                     ok, w_cnt, pop_cnt, w_last_log[0]);
        end
        n_tests++;
        if (w_data_log[0] !== 32'hA5A5_0000 + 32'(base)) begin
            n_fail++;
            $display("FAIL n1_data: got %h want %h", w_data_log[0], 32'hA5A5_0000 + 32'(base));
        end
    endtask

    task automatic test_zero();
        clear_logs();
        start_burst(8'd0, 16'h0400);
        n_tests++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL n0_valid: got %b want 1", valid);
        end
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (awv_cyc !== 0 || wv_cyc !== 0 || rv_cyc !== 0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL n0_quiet: aw=%0d w=%0d rv=%0d valid=%b want 0 0 0 1",
                     awv_cyc, wv_cyc, rv_cyc, valid);
        end
    endtask

    task automatic test_wready_stall();
        bit ok, found;
        int base;
        clear_logs();
        base = fifo_idx;
        start_burst(8'd3, 16'h0500);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (wvalid && w_cnt == 1) found = 1'b1;
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_find: beat 2 never presented");
        end
        wready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (wvalid !== 1'b1 || wlast !== 1'b0 || wdata !== 32'hA5A5_0000 + 32'(base + 1)
                || pop_cnt !== 2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: wv=%b last=%b data=%h pop=%0d want 1 0 %h 2",
                         c, wvalid, wlast, wdata, 32'hA5A5_0000 + 32'(base + 1), pop_cnt);
            end
        end
        wready = 1'b1;
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1 || w_cnt !== 3 || pop_cnt !== 3) begin
            n_fail++;
            $display("FAIL stall_end: done=%b w=%0d pop=%0d want 1 3 3", ok, w_cnt, pop_cnt);
        end
        n_tests++;
        if (w_data_log[2] !== 32'hA5A5_0000 + 32'(base + 2) || w_last_log[2] !== 1'b1
            || w_last_log[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_tail: data=%h last=%b%b want %h 01", w_data_log[2],
                     w_last_log[1], w_last_log[2], 32'hA5A5_0000 + 32'(base + 2));
        end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int pops, beats, base;
        clear_logs();
        wready = 1'b0;
        start_burst(8'd4, 16'h0600);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (wvalid) found = 1'b1;
            else step();
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_find: SEND never reached");
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({wvalid, awvalid, arg_0_read_valid, bready, wlast, valid} !== 6'b0
            || wdata !== 32'h0 || awaddr !== 16'h0 || awlen !== 8'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: ctl=%b data=%h addr=%h len=%h want 0",
                     {wvalid, awvalid, arg_0_read_valid, bready, wlast, valid}, wdata, awaddr, awlen);
        end
        pops = pop_cnt;
        beats = w_cnt;
        wready = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if (pop_cnt !== pops || w_cnt !== beats || aw_cnt !== 1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: pop=%0d w=%0d aw=%0d valid=%b want %0d %0d 1 0",
                     pop_cnt, w_cnt, aw_cnt, valid, pops, beats);
        end
        clear_logs();
        base = fifo_idx;
        start_burst(8'd2, 16'h0300);
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1 || w_cnt !== 2 || pop_cnt !== 2 || aw_addr_log !== 16'h0300
            || aw_len_log !== 8'd1) begin
            n_fail++;
            $display("FAIL rstmid_rerun: done=%b w=%0d pop=%0d addr=%h len=%0d want 1 2 2 0300 1",
                     ok, w_cnt, pop_cnt, aw_addr_log, aw_len_log);
        end
        n_tests++;
        if (w_data_log[0] !== 32'hA5A5_0000 + 32'(base) || w_data_log[1] !== 32'hA5A5_0000 + 32'(base + 1)
            || w_last_log[0] !== 1'b0 || w_last_log[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_data: %h %h last=%b%b want %h %h 01", w_data_log[0], w_data_log[1],
                     w_last_log[0], w_last_log[1], 32'hA5A5_0000 + 32'(base),
                     32'hA5A5_0000 + 32'(base + 1));
        end
    endtask

    task automatic test_bresp();
        bit ok;
        logic exp_err;
`ifdef AXI_WB_BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_logs();
        bresp = 2'b10;
        start_burst(8'd1, 16'h0700);
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1 || err !== exp_err) begin
            n_fail++;
            $display("FAIL bresp_err: done=%b err=%b want 1 %b", ok, err, exp_err);
        end
        step();
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL bresp_sticky: err=%b want %b", err, exp_err);
        end
        bresp = 2'b00;
        start_burst(8'd1, 16'h0700);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL bresp_clear: err=%b want 0", err);
        end
        wait_done(ok);
        n_tests++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bresp_okay: done=%b err=%b want 1 0", ok, err);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_burst4();
        test_single();
        test_zero();
        test_wready_stall();
        test_reset_mid();
        test_bresp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wb.md
AXI_WB -- requirements
Module: axi_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI write-data and FIFO width.
REQ-002 SHALL have parameter ADDR_W, default 16, AXI address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request, sampled in IDLE/DONE
- arg_1_rdata  in  8  beat count N, latched on start
- arg_2_rdata  in  ADDR_W  burst base address, latched on start
- arg_0_out_data  in  DATA_W  FIFO head data
- arg_0_read_ready  in  1  FIFO has data; pop accepted this cycle
- arg_0_read_valid  out  1  pop request
- arg_3_s_axi_awaddr  out  ADDR_W  latched base address
- arg_3_s_axi_awlen  out  8  N-1
- arg_3_s_axi_awsize  out  3  constant 3'b010
- arg_3_s_axi_awburst  out  2  constant 2'b01 (INCR)
- arg_3_s_axi_awvalid  out  1  address valid
- arg_3_s_axi_awready  in  1  address accepted
- arg_3_s_axi_wdata  out  DATA_W  beat data register
- arg_3_s_axi_wstrb  out  DATA_W/8  all ones
- arg_3_s_axi_wlast  out  1  final beat
- arg_3_s_axi_wvalid  out  1  beat valid
- arg_3_s_axi_wready  in  1  beat accepted
- arg_3_s_axi_bresp  in  2  write response
- arg_3_s_axi_bvalid  in  1  response valid
- arg_3_s_axi_bready  out  1  response ready
- valid  out  1  burst complete
- err  out  1  sticky response error

Function
REQ-005 SHALL implement states IDLE, AW, FETCH, SEND, BWAIT, DONE.
REQ-006 SHALL, on start in IDLE/DONE with N>=1, latch N and address, clear beat counter and err, enter AW next cycle; start in other states ignored.
REQ-007 SHALL, on start with N=0, go directly to DONE with no AXI traffic.
REQ-008 SHALL drive awvalid=1 only in AW, holding awaddr/awlen stable; on awready go to FETCH.
REQ-009 SHALL drive arg_0_read_valid=1 only in FETCH; in a cycle where arg_0_read_ready=1, capture arg_0_out_data into wdata and go to SEND; otherwise stay in FETCH.
REQ-010 SHALL drive wvalid=1 only in SEND, wdata stable until wready; wlast=1 iff beat counter equals N-1.
REQ-011 SHALL, on wready in SEND, increment the 8-bit beat counter and go to FETCH if not last, else BWAIT.
REQ-012 SHALL drive bready=1 only in BWAIT; on bvalid go to DONE.
REQ-013 SHALL drive valid=1 throughout DONE and 0 elsewhere.
REQ-014 SHALL never pop more than N FIFO words per burst; no FIFO pop while wvalid pending.
REQ-015 SHALL give minimum latency start to awvalid of 1 cycle; each beat costs at least 2 cycles (FETCH+SEND).

Reset
REQ-016 SHALL, on rst (asynchronously), enter IDLE; all valid/ready outputs, wlast, err, valid =0; wdata, awaddr, awlen, beat counter =0.
REQ-017 SHALL abandon an in-flight burst on rst with no further AXI or FIFO handshakes.

Configuration
REQ-018 SHALL, with AXI_WB_BRESP_CHECK_EN defined, set err=1 in DONE when the accepted bresp is non-zero, held until next start; without it, bresp ignored and err tied 0.

Structure
REQ-019 SHALL place state encoding, AXI_BURST_INCR, AXI_SIZE_4B and response codes in shared package axi_wb_pkg.
REQ-020 SHALL use no sub-module; counter and FSM inline.

Verification
REQ-021 SHALL cover: N=4, addr 16'h0100, all readies high -> awlen=3, four beats with FIFO data in order, wlast on beat 4 only, valid high after bvalid.
REQ-022 SHALL cover: N=1 -> single beat with wlast=1, exactly one pop.
REQ-023 SHALL cover: N=0 -> valid next cycle, no awvalid/wvalid/read_valid ever.
REQ-024 SHALL cover: wready low 3 cycles on beat 2 -> wdata held, no extra pop.
REQ-025 SHALL cover: rst asserted mid-SEND -> outputs zero immediately, IDLE, later start runs cleanly.
REQ-026 SHALL cover: bresp=2'b10 with macro defined -> err=1 in DONE; undefined -> err=0.
